// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register (hold, shift left, shift right, parallel load)
// Output is taken straight from the state flops, so no input reaches it without a clock edge.

module universal_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_right_in,
   input  logic             serial_left_in,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] parallel_data_out
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;

   // Undefined sel values fall through to hold.
   always_comb begin
      w_next = r_q;
      case (sel)
         2'b00:   w_next = r_q;
         2'b01:   w_next = {r_q[WIDTH-2:0], serial_left_in};
         2'b10:   w_next = {serial_right_in, r_q[WIDTH-1:1]};
         2'b11:   w_next = parallel_in;
         default: w_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_next;
      end
   end

   assign parallel_data_out = r_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
// Table vectors and hand sequences push expectations to a queue; each edge pops and compares.

module tb_universal_shift_reg;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             serial_right_in;
   logic             serial_left_in;
   logic [1:0]       sel;
   logic [WIDTH-1:0] parallel_in;
   logic [WIDTH-1:0] parallel_data_out;

   int checks;
   int failures;

   logic [WIDTH-1:0] exp_q[$];

   typedef struct {
      logic             rst;
      logic [1:0]       sel;
      logic             sr;
      logic             sl;
      logic [WIDTH-1:0] pin;
      logic [WIDTH-1:0] exp;
      string            name;
   } vec_t;

   vec_t vecs[$];

   universal_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .serial_right_in   (serial_right_in),
      .serial_left_in    (serial_left_in),
      .sel               (sel),
      .parallel_in       (parallel_in),
      .parallel_data_out (parallel_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic [1:0] s, input logic sr,
                               input logic sl, input logic [WIDTH-1:0] pin,
                               input logic [WIDTH-1:0] e, input string n);
      vec_t v;
      v.rst = rst; v.sel = s; v.sr = sr; v.sl = sl; v.pin = pin; v.exp = e; v.name = n;
      return v;
   endfunction

   task automatic compare(input string name);
      logic [WIDTH-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty, got %b", name, parallel_data_out);
      end else begin
         e = exp_q.pop_front();
         if (parallel_data_out !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, parallel_data_out, e);
         end
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] s, input logic sr, input logic sl,
                       input logic [WIDTH-1:0] pin, input logic [WIDTH-1:0] e, input string name);
      @(negedge clk);
      reset = rst; sel = s; serial_right_in = sr; serial_left_in = sl; parallel_in = pin;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare(name);
   endtask

   logic [WIDTH-1:0] model_q;
   logic [1:0]       rs;
   logic             rsr, rsl, rrst;
   logic [WIDTH-1:0] rpin;

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0; sel = 2'b00; serial_right_in = 1'b0; serial_left_in = 1'b0; parallel_in = '0;

      vecs.push_back(mk(1, 2'b11, 1, 1, 4'b1010, 4'b0000, "reset"));
      vecs.push_back(mk(0, 2'b00, 1, 1, 4'b1111, 4'b0000, "hold0_a"));
      vecs.push_back(mk(0, 2'b00, 0, 0, 4'b0101, 4'b0000, "hold0_b"));
      vecs.push_back(mk(0, 2'b00, 1, 0, 4'b1111, 4'b0000, "hold0_c"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1000, "sr_fill1"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1100, "sr_fill2"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1110, "sr_fill3"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1111, "sr_fill4"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1111, "sr_fill5"));
      vecs.push_back(mk(0, 2'b10, 0, 1, 4'b0000, 4'b0111, "sr_zero"));
      vecs.push_back(mk(1, 2'b01, 1, 1, 4'b1111, 4'b0000, "reset2"));
      vecs.push_back(mk(0, 2'b01, 0, 1, 4'b0000, 4'b0001, "sl_fill1"));
      vecs.push_back(mk(0, 2'b01, 0, 1, 4'b0000, 4'b0011, "sl_fill2"));
      vecs.push_back(mk(0, 2'b01, 0, 1, 4'b0000, 4'b0111, "sl_fill3"));
      vecs.push_back(mk(0, 2'b01, 0, 1, 4'b0000, 4'b1111, "sl_fill4"));
      vecs.push_back(mk(0, 2'b01, 1, 0, 4'b0000, 4'b1110, "sl_zero"));
      vecs.push_back(mk(0, 2'b11, 0, 0, 4'b1111, 4'b1111, "load_1111"));
      vecs.push_back(mk(0, 2'b11, 0, 0, 4'b1010, 4'b1010, "load_1010"));
      vecs.push_back(mk(0, 2'b00, 1, 1, 4'b0101, 4'b1010, "hold_1010"));
      vecs.push_back(mk(1, 2'b00, 0, 0, 4'b0000, 4'b0000, "reset3"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1000, "mid_sr1"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1100, "mid_sr2"));
      vecs.push_back(mk(1, 2'b10, 1, 0, 4'b1111, 4'b0000, "mid_reset"));
      vecs.push_back(mk(0, 2'b10, 1, 0, 4'b0000, 4'b1000, "mid_resume"));
      vecs.push_back(mk(0, 2'b11, 0, 0, 4'b1001, 4'b1001, "bb_load"));
      vecs.push_back(mk(0, 2'b01, 1, 0, 4'b0000, 4'b0010, "bb_sl"));
      vecs.push_back(mk(0, 2'b10, 1, 1, 4'b0000, 4'b1001, "bb_sr"));
      vecs.push_back(mk(0, 2'b00, 0, 0, 4'b0110, 4'b1001, "bb_hold"));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].sel, vecs[i].sr, vecs[i].sl, vecs[i].pin, vecs[i].exp, vecs[i].name);
      end

      // Inputs wiggled between edges, including a reset pulse, must be ignored.
      @(negedge clk);
      reset = 1'b0; sel = 2'b00; parallel_in = 4'b0110;
      exp_q.push_back(4'b1001);
      @(posedge clk);
      #2 sel = 2'b11; reset = 1'b1;
      #1 compare("between_edge_glitch");
      #1 sel = 2'b00; reset = 1'b0;
      exp_q.push_back(4'b1001);
      @(posedge clk);
      #1 compare("glitch_ignored_at_edge");

      // Random stream against an independent behavioural model.
      model_q = 4'b1001;
      for (int i = 0; i < 60; i++) begin
         rs   = 2'($urandom_range(0, 3));
         rsr  = 1'($urandom_range(0, 1));
         rsl  = 1'($urandom_range(0, 1));
         rpin = 4'($urandom_range(0, 15));
         rrst = ($urandom_range(0, 15) == 0);
         if (rrst) model_q = '0;
         else begin
            case (rs)
               2'b01:   model_q = {model_q[2:0], rsl};
               2'b10:   model_q = {rsr, model_q[3:1]};
               2'b11:   model_q = rpin;
               default: model_q = model_q;
            endcase
         end
         step(rrst, rs, rsr, rsl, rpin, model_q, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
